// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception codes, redirect FSM states, flush bits.
package cpu_defs;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_NORM = 2'd1;
    localparam logic [1:0] EXC_BD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2,
        S_REDIR = 2'd3
    } redir_state_t;

    localparam int FL_IF  = 0;
    localparam int FL_ID  = 1;
    localparam int FL_EX  = 2;
    localparam int FL_MEM = 3;

    localparam logic [3:0] FLUSH_ALL = 4'b1111;

endpackage

// File: rtl/exc_redirect.sv
// Exception/ERET redirect controller: latches the CP0 target, flushes the
// pipeline for a fixed number of cycles, then hands the PC to fetch.
module exc_redirect
    import cpu_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  exc,
    input  logic        back,
    input  logic [31:0] epc,
    input  logic        pause,
    input  logic        redirect_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [3:0]  flush,
    output logic        in_bd,
    output logic        busy
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    redir_state_t state;
    logic [3:0]   cnt;
    logic         req;
    logic [31:0]  req_pc;
    logic         req_bd;

    // Exception wins over ERET; code 3 behaves like a plain exception.
    always_comb begin
        req    = (exc != EXC_NONE) || back;
        req_pc = (exc != EXC_NONE) ? EXC_VECTOR : epc;
        req_bd = (exc == EXC_BD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            redirect_pc    <= '0;
            in_bd          <= 1'b0;
            redirect_valid <= 1'b0;
            flush          <= '0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        redirect_pc <= req_pc;
                        in_bd       <= req_bd;
                        busy        <= 1'b1;
                        if (pause) begin
                            state <= S_PEND;
                        end else begin
                            state <= S_FLUSH;
                            cnt   <= FLUSH_LOAD;
                            flush <= FLUSH_ALL;
                        end
                    end
                end
                S_PEND: begin
                    if (!pause) begin
                        state <= S_FLUSH;
                        cnt   <= FLUSH_LOAD;
                        flush <= FLUSH_ALL;
                    end
                end
                S_FLUSH: begin
                    if (cnt == 4'd1) begin
                        state          <= S_REDIR;
                        cnt            <= '0;
                        flush          <= '0;
                        redirect_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_REDIR: begin
                    if (redirect_ready) begin
                        state          <= S_IDLE;
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_redirect.sv
// Randomized and directed bench for exc_redirect with a timestamp-based
// reference model of the redirect sequence.
module tb_exc_redirect;

    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [1:0]  exc   = 2'd0;
    logic        back  = 1'b0;
    logic [31:0] epc   = 32'd0;
    logic        pause = 1'b0;
    logic        ready = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  flush;
    logic        in_bd;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    exc_redirect #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
        .clk(clk),
        .rst(rst),
        .exc(exc),
        .back(back),
        .epc(epc),
        .pause(pause),
        .redirect_ready(ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .flush(flush),
        .in_bd(in_bd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: a redirect is "active" from acceptance; flushing starts at the
    // edge fstart and lasts F edges, after which the target is offered.
    bit          m_on   = 0;
    bit          m_act  = 0;
    bit          m_pend = 0;
    int          cyc    = 0;
    int          fstart = 0;
    logic [31:0] m_tgt  = 32'd0;
    logic        m_bd   = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_on   = 1;
            m_act  = 0;
            m_pend = 0;
            m_tgt  = 32'd0;
            m_bd   = 1'b0;
        end else if (m_on) begin
            if (m_act && !m_pend && (cyc - fstart > F) && ready) begin
                m_act = 0;
            end else if (!m_act) begin
                if (exc != 2'd0 || back) begin
                    m_act  = 1;
                    m_tgt  = (exc != 2'd0) ? VEC : epc;
                    m_bd   = (exc == 2'd2);
                    m_pend = pause;
                    fstart = cyc;
                end
            end else if (m_pend && !pause) begin
                m_pend = 0;
                fstart = cyc;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    task automatic cmp_model();
        logic [3:0] e_flush;
        logic       e_valid;
        if (!m_on) return;
        e_flush = (m_act && !m_pend && (cyc - fstart < F)) ? 4'hF : 4'h0;
        e_valid = m_act && !m_pend && (cyc - fstart >= F);
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_valid", 32'(redirect_valid), 32'(e_valid));
        chk("m_busy", 32'(busy), 32'(m_act));
        chk("m_pc", redirect_pc, m_tgt);
        chk("m_in_bd", 32'(in_bd), 32'(m_bd));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        // reset
        tick();
        tick();
        chk("rst_valid", 32'(redirect_valid), 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst   = 1'b1;
        ready = 1'b1;
        tick();

        // plain exception
        exc = 2'd1;
        tick();
        chk("t1_flush1", 32'(flush), 32'hF);
        chk("t1_busy", 32'(busy), 32'd1);
        exc = 2'd0;
        tick();
        chk("t1_flush2", 32'(flush), 32'hF);
        tick();
        chk("t1_valid", 32'(redirect_valid), 32'd1);
        chk("t1_pc", redirect_pc, 32'hBFC00380);
        chk("t1_bd", 32'(in_bd), 32'd0);
        chk("t1_flush0", 32'(flush), 32'd0);
        tick();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_novalid", 32'(redirect_valid), 32'd0);

        // ERET, epc sampled only on the request cycle
        back = 1'b1;
        epc  = 32'hBFC00704;
        tick();
        back = 1'b0;
        epc  = 32'd0;
        tick();
        tick();
        chk("t2_valid", 32'(redirect_valid), 32'd1);
        chk("t2_pc", redirect_pc, 32'hBFC00704);
        tick();

        // exception in delay slot beats ERET
        exc  = 2'd2;
        back = 1'b1;
        epc  = 32'h0000_1234;
        tick();
        exc  = 2'd0;
        back = 1'b0;
        tick();
        tick();
        chk("t3_pc", redirect_pc, 32'hBFC00380);
        chk("t3_bd", 32'(in_bd), 32'd1);
        tick();

        // deferred by pause for three cycles
        pause = 1'b1;
        exc   = 2'd1;
        tick();
        chk("t4_pend_busy", 32'(busy), 32'd1);
        chk("t4_pend_fl1", 32'(flush), 32'd0);
        exc = 2'd0;
        tick();
        chk("t4_pend_fl2", 32'(flush), 32'd0);
        tick();
        chk("t4_pend_fl3", 32'(flush), 32'd0);
        pause = 1'b0;
        tick();
        chk("t4_flush", 32'(flush), 32'hF);
        tick();
        tick();
        chk("t4_valid", 32'(redirect_valid), 32'd1);
        chk("t4_pc", redirect_pc, 32'hBFC00380);
        chk("t4_bd", 32'(in_bd), 32'd0);
        tick();

        // fetch back-pressure; request during REDIR is dropped
        ready = 1'b0;
        exc   = 2'd1;
        tick();
        exc = 2'd0;
        tick();
        tick();
        chk("t5_valid0", 32'(redirect_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            exc = (i == 1) ? 2'd1 : 2'd0;
            tick();
            chk("t5_valid_hold", 32'(redirect_valid), 32'd1);
            chk("t5_pc_hold", redirect_pc, 32'hBFC00380);
        end
        exc   = 2'd0;
        ready = 1'b1;
        tick();
        chk("t5_done", 32'(redirect_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_dropped", 32'(busy), 32'd0);

        // reset in the second flush cycle
        exc = 2'd2;
        tick();
        exc = 2'd0;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_flush", 32'(flush), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pc", redirect_pc, 32'd0);
        chk("t6_bd", 32'(in_bd), 32'd0);
        rst = 1'b1;
        exc = 2'd1;
        tick();
        chk("t6_reflush", 32'(flush), 32'hF);
        exc = 2'd0;
        tick();
        tick();
        chk("t6_valid", 32'(redirect_valid), 32'd1);
        chk("t6_repc", redirect_pc, 32'hBFC00380);
        tick();
        chk("t6_idle", 32'(busy), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 99) != 0);
            exc   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
            back  = ($urandom_range(0, 7) == 0);
            epc   = $urandom;
            pause = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
